// File: rtl/phy_lane_checker.sv
// Lane-by-lane A/B stream comparator with per-lane skew FIFOs, saturating
// match/mismatch counters, first-error capture and an error-budget FAIL state.
module phy_lane_checker #(
  parameter int unsigned N       = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned MAX_ERR = 3
) (
  input  logic                 clk_f,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [N-1:0]         valid_a,
  input  logic [N*W-1:0]       data_a,
  input  logic [N-1:0]         valid_b,
  input  logic [N*W-1:0]       data_b,
  output logic [CNT_W-1:0]     match_cnt,
  output logic [CNT_W-1:0]     mismatch_cnt,
  output logic                 error,
  output logic [N-1:0]         overflow,
  output logic [$clog2(N)-1:0] first_err_lane,
  output logic [W-1:0]         first_err_a,
  output logic [W-1:0]         first_err_b,
  output logic [1:0]           state
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned LW  = $clog2(N);
  localparam int unsigned NCW = $clog2(N + 1);
  localparam int unsigned SW  = CNT_W + NCW;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StCheck = 2'b01,
    StFail  = 2'b10
  } state_e;

  state_e state_q, state_d;

  logic [W-1:0]    mem_a_q [N][DEPTH];
  logic [W-1:0]    mem_b_q [N][DEPTH];
  logic [AW:0]     wa_q [N];
  logic [AW:0]     ra_q [N];
  logic [AW:0]     wb_q [N];
  logic [AW:0]     rb_q [N];
  logic [AW:0]     wa_d [N];
  logic [AW:0]     ra_d [N];
  logic [AW:0]     wb_d [N];
  logic [AW:0]     rb_d [N];

  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] mis_q, mis_d;
  logic             err_q, err_d;
  logic [N-1:0]     ovf_q, ovf_d;
  logic [LW-1:0]    fe_lane_q, fe_lane_d;
  logic [W-1:0]     fe_a_q, fe_a_d;
  logic [W-1:0]     fe_b_q, fe_b_d;

  logic             active;
  logic             flush;
  logic [N-1:0]     empty_a, empty_b, full_a, full_b;
  logic [N-1:0]     push_a, push_b, pop, drop, hit, miss;
  logic [W-1:0]     head_a [N];
  logic [W-1:0]     head_b [N];
  logic [NCW-1:0]   n_hit, n_miss;
  logic             fe_found;
  logic [LW-1:0]    fe_lane;
  logic [W-1:0]     fe_a, fe_b;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [NCW-1:0]   b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    if (s > SW'({CNT_W{1'b1}})) begin
      return {CNT_W{1'b1}};
    end
    return s[CNT_W-1:0];
  endfunction

  // FIFO status, push/pop decisions and per-lane comparison of the FIFO heads.
  always_comb begin
    active  = (state_q == StCheck) && enable;
    empty_a = '0;
    empty_b = '0;
    full_a  = '0;
    full_b  = '0;
    push_a  = '0;
    push_b  = '0;
    pop     = '0;
    drop    = '0;
    hit     = '0;
    miss    = '0;
    for (int i = 0; i < N; i++) begin
      empty_a[i] = (wa_q[i] == ra_q[i]);
      empty_b[i] = (wb_q[i] == rb_q[i]);
      full_a[i]  = (wa_q[i][AW] != ra_q[i][AW]) && (wa_q[i][AW-1:0] == ra_q[i][AW-1:0]);
      full_b[i]  = (wb_q[i][AW] != rb_q[i][AW]) && (wb_q[i][AW-1:0] == rb_q[i][AW-1:0]);
      head_a[i]  = mem_a_q[i][ra_q[i][AW-1:0]];
      head_b[i]  = mem_b_q[i][rb_q[i][AW-1:0]];
      pop[i]     = active && !empty_a[i] && !empty_b[i];
      // A pop frees a slot on the same edge, so a full FIFO still accepts a push.
      push_a[i]  = active && valid_a[i] && (!full_a[i] || pop[i]);
      push_b[i]  = active && valid_b[i] && (!full_b[i] || pop[i]);
      drop[i]    = active && ((valid_a[i] && full_a[i] && !pop[i]) ||
                              (valid_b[i] && full_b[i] && !pop[i]));
      hit[i]     = pop[i] && (head_a[i] == head_b[i]);
      miss[i]    = pop[i] && (head_a[i] != head_b[i]);
    end
  end

  // Tally this edge's results; scanning downward leaves the lowest failing lane.
  always_comb begin
    n_hit    = '0;
    n_miss   = '0;
    fe_found = 1'b0;
    fe_lane  = '0;
    fe_a     = '0;
    fe_b     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) begin
        n_hit = n_hit + NCW'(1);
      end
      if (miss[i]) begin
        n_miss   = n_miss + NCW'(1);
        fe_found = 1'b1;
        fe_lane  = LW'(i);
        fe_a     = head_a[i];
        fe_b     = head_b[i];
      end
    end
  end

  always_comb begin
    match_d   = sat_add(match_q, n_hit);
    mis_d     = sat_add(mis_q, n_miss);
    ovf_d     = ovf_q | drop;
    err_d     = err_q;
    fe_lane_d = fe_lane_q;
    fe_a_d    = fe_a_q;
    fe_b_d    = fe_b_q;
    if (!err_q && fe_found) begin
      err_d     = 1'b1;
      fe_lane_d = fe_lane;
      fe_a_d    = fe_a;
      fe_b_d    = fe_b;
    end
  end

  always_comb begin
    state_d = state_q;
    flush   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (!enable) begin
          state_d = StIdle;
          flush   = 1'b1;
        end else if ((MAX_ERR != 0) && (64'(mis_d) >= 64'(MAX_ERR))) begin
          state_d = StFail;
        end
      end
      StFail: begin
        state_d = StFail;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (flush) begin
        wa_d[i] = '0;
        ra_d[i] = '0;
        wb_d[i] = '0;
        rb_d[i] = '0;
      end else begin
        wa_d[i] = wa_q[i] + {{AW{1'b0}}, push_a[i]};
        ra_d[i] = ra_q[i] + {{AW{1'b0}}, pop[i]};
        wb_d[i] = wb_q[i] + {{AW{1'b0}}, push_b[i]};
        rb_d[i] = rb_q[i] + {{AW{1'b0}}, pop[i]};
      end
    end
  end

  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      match_q   <= '0;
      mis_q     <= '0;
      err_q     <= 1'b0;
      ovf_q     <= '0;
      fe_lane_q <= '0;
      fe_a_q    <= '0;
      fe_b_q    <= '0;
      for (int i = 0; i < N; i++) begin
        wa_q[i] <= '0;
        ra_q[i] <= '0;
        wb_q[i] <= '0;
        rb_q[i] <= '0;
      end
    end else if (clear) begin
      state_q   <= StIdle;
      match_q   <= '0;
      mis_q     <= '0;
      err_q     <= 1'b0;
      ovf_q     <= '0;
      fe_lane_q <= '0;
      fe_a_q    <= '0;
      fe_b_q    <= '0;
      for (int i = 0; i < N; i++) begin
        wa_q[i] <= '0;
        ra_q[i] <= '0;
        wb_q[i] <= '0;
        rb_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      mis_q     <= mis_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
      fe_lane_q <= fe_lane_d;
      fe_a_q    <= fe_a_d;
      fe_b_q    <= fe_b_d;
      for (int i = 0; i < N; i++) begin
        wa_q[i] <= wa_d[i];
        ra_q[i] <= ra_d[i];
        wb_q[i] <= wb_d[i];
        rb_q[i] <= rb_d[i];
      end
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk_f) begin
    for (int i = 0; i < N; i++) begin
      if (push_a[i]) begin
        mem_a_q[i][wa_q[i][AW-1:0]] <= data_a[i*W +: W];
      end
      if (push_b[i]) begin
        mem_b_q[i][wb_q[i][AW-1:0]] <= data_b[i*W +: W];
      end
    end
  end

  assign match_cnt      = match_q;
  assign mismatch_cnt   = mis_q;
  assign error          = err_q;
  assign overflow       = ovf_q;
  assign first_err_lane = fe_lane_q;
  assign first_err_a    = fe_a_q;
  assign first_err_b    = fe_b_q;
  assign state          = state_q;

endmodule
